// File: rtl/stack_seq_if.sv
// Stack sequencer bus: operation request, register-file, SP, memory and PC
// signals. The master drives requests and read data; the slave is stack_seq.
interface stack_seq_if;
   logic       op_valid;
   logic [1:0] op_code;
   logic [1:0] op_reg;
   logic [7:0] pc_in;
   logic [7:0] target_in;
   logic [7:0] sp_in;
   logic [7:0] rf_rdata;
   logic [7:0] mem_rdata;
   logic       mem_ready;
   logic       op_ready;
   logic [1:0] rf_ra;
   logic       rf_we;
   logic [1:0] rf_wa;
   logic [7:0] rf_wd;
   logic       sp_en;
   logic       sp_op;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic       mem_re;
   logic       pc_load;
   logic [7:0] pc_out;
   logic       done;
   logic       stack_err;

   modport master (
      output op_valid, op_code, op_reg, pc_in, target_in,
             sp_in, rf_rdata, mem_rdata, mem_ready,
      input  op_ready, rf_ra, rf_we, rf_wa, rf_wd, sp_en, sp_op,
             mem_addr, mem_wdata, mem_we, mem_re, pc_load, pc_out,
             done, stack_err
   );

   modport slave (
      input  op_valid, op_code, op_reg, pc_in, target_in,
             sp_in, rf_rdata, mem_rdata, mem_ready,
      output op_ready, rf_ra, rf_we, rf_wa, rf_wd, sp_en, sp_op,
             mem_addr, mem_wdata, mem_we, mem_re, pc_load, pc_out,
             done, stack_err
   );
endinterface

// File: rtl/stack_seq.sv
// Stack sequencer: PUSH/POP/CALL/RET over an external SP (R3) and data memory.
// Ports: clk, rst (async, active-low), bus (stack_seq_if.slave).
// Define STACK_SEQ_GUARD_EN to reject PUSH/CALL at SP=0 and POP/RET at SP=255.
module stack_seq (
   input  logic        clk,
   input  logic        rst,
   stack_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      MEM_WR,
      SP_INC,
      MEM_RD,
      DONE
   } state_t;

   localparam logic [1:0] OP_CALL = 2'b10;

   state_t     state;
   logic [1:0] code_q;
   logic [1:0] reg_q;
   logic [7:0] data_q;
   logic [7:0] tgt_q;

   // PUSH (00) and CALL (10) write memory; POP/RET read it.
   logic is_wr;
   assign is_wr = ~bus.op_code[0];

`ifdef STACK_SEQ_GUARD_EN
   logic err_q;
   logic guard_hit;
   assign guard_hit = is_wr ? (bus.sp_in == 8'h00)
                            : (bus.sp_in == 8'hFF);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         code_q <= 2'b00;
         reg_q  <= 2'b00;
         data_q <= 8'h00;
         tgt_q  <= 8'h00;
`ifdef STACK_SEQ_GUARD_EN
         err_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.op_valid) begin
                  code_q <= bus.op_code;
                  reg_q  <= bus.op_reg;
                  data_q <= bus.op_code[1] ? bus.pc_in : bus.rf_rdata;
                  tgt_q  <= bus.target_in;
`ifdef STACK_SEQ_GUARD_EN
                  err_q  <= guard_hit;
                  if (guard_hit)  state <= DONE;
                  else if (is_wr) state <= MEM_WR;
                  else            state <= SP_INC;
`else
                  state  <= is_wr ? MEM_WR : SP_INC;
`endif
               end
            end
            MEM_WR: if (bus.mem_ready) state <= DONE;
            SP_INC: state <= MEM_RD;
            MEM_RD: if (bus.mem_ready) state <= DONE;
            DONE: begin
               state <= IDLE;
`ifdef STACK_SEQ_GUARD_EN
               err_q <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rf_ra    = bus.op_reg;
   assign bus.op_ready = (state == IDLE);

   // Strobes decode from the registered state; completion strobes also
   // need mem_ready in the same cycle, so they cannot be registered.
   always_comb begin
      bus.rf_we     = 1'b0;
      bus.rf_wa     = 2'b00;
      bus.rf_wd     = 8'h00;
      bus.sp_en     = 1'b0;
      bus.sp_op     = 1'b0;
      bus.mem_addr  = 8'h00;
      bus.mem_wdata = 8'h00;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.pc_load   = 1'b0;
      bus.pc_out    = 8'h00;
      bus.done      = 1'b0;
      bus.stack_err = 1'b0;
      unique case (state)
         MEM_WR: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.sp_in;
            bus.mem_wdata = data_q;
            // Post-decrement SP once the write lands.
            if (bus.mem_ready) begin
               bus.sp_en = 1'b1;
               if (code_q == OP_CALL) begin
                  bus.pc_load = 1'b1;
                  bus.pc_out  = tgt_q;
               end
            end
         end
         SP_INC: begin
            bus.sp_en = 1'b1;
            bus.sp_op = 1'b1;
         end
         MEM_RD: begin
            bus.mem_re   = 1'b1;
            bus.mem_addr = bus.sp_in;
            if (bus.mem_ready) begin
               if (code_q[1]) begin
                  bus.pc_load = 1'b1;
                  bus.pc_out  = bus.mem_rdata;
               end else begin
                  bus.rf_we = 1'b1;
                  bus.rf_wa = reg_q;
                  bus.rf_wd = bus.mem_rdata;
               end
            end
         end
         DONE: begin
            bus.done = 1'b1;
`ifdef STACK_SEQ_GUARD_EN
            bus.stack_err = err_q;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: PUSH, POP, CALL with wait states, RET with
// busy-time requests, mid-operation reset and SP boundary (guard or wrap).
module tb_stack_seq;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   stack_seq_if bus ();

   stack_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {rf_we, sp_en, mem_we, mem_re, pc_load, done, stack_err}
   function automatic logic [6:0] strb();
      return {bus.rf_we, bus.sp_en, bus.mem_we, bus.mem_re,
              bus.pc_load, bus.done, bus.stack_err};
   endfunction

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests          = 0;
      fails          = 0;
      rst            = 1'b0;
      bus.op_valid   = 1'b0;
      bus.op_code    = 2'b00;
      bus.op_reg     = 2'b01;
      bus.pc_in      = 8'h00;
      bus.target_in  = 8'h00;
      bus.sp_in      = 8'h00;
      bus.rf_rdata   = 8'h00;
      bus.mem_rdata  = 8'h00;
      bus.mem_ready  = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", bus.op_ready, 1);
      chk("rst_strb", strb(), 0);
      chk("rst_rf_ra", bus.rf_ra, 1);
      chk("rst_data", {bus.rf_wa, bus.rf_wd, bus.sp_op, bus.mem_addr,
                       bus.mem_wdata, bus.pc_out}, 0);
      @(negedge clk);
      rst = 1'b1;

      // PUSH R1=5A at SP=FF
      bus.rf_rdata  = 8'h5A;
      bus.sp_in     = 8'hFF;
      bus.mem_ready = 1'b1;
      bus.op_valid  = 1'b1;
      bus.op_code   = 2'b00;
      bus.op_reg    = 2'b01;
      #1;
      chk("push_ready", bus.op_ready, 1);
      @(negedge clk);
      bus.op_valid = 1'b0;
      #1;
      chk("push_wr_strb", strb(), 7'b0110000);
      chk("push_wr", {bus.mem_addr, bus.mem_wdata, bus.sp_op,
                      bus.op_ready}, {8'hFF, 8'h5A, 1'b0, 1'b0});
      @(negedge clk);
      bus.sp_in = 8'hFE;
      #1;
      chk("push_done", strb(), 7'b0000010);
      @(negedge clk);
      #1;
      chk("push_idle", {bus.op_ready, strb()}, {1'b1, 7'b0});

      // POP R2, SP FE->FF, mem=3C
      bus.op_valid  = 1'b1;
      bus.op_code   = 2'b01;
      bus.op_reg    = 2'b10;
      bus.mem_rdata = 8'h3C;
      @(negedge clk);
      bus.op_valid = 1'b0;
      #1;
      chk("pop_inc_strb", strb(), 7'b0100000);
      chk("pop_inc_op", bus.sp_op, 1);
      @(negedge clk);
      bus.sp_in = 8'hFF;
      #1;
      chk("pop_rd_strb", strb(), 7'b1001000);
      chk("pop_rd", {bus.mem_addr, bus.rf_wa, bus.rf_wd},
                    {8'hFF, 2'b10, 8'h3C});
      @(negedge clk);
      #1;
      chk("pop_done", strb(), 7'b0000010);
      @(negedge clk);
      #1;
      chk("pop_idle", bus.op_ready, 1);

      // CALL pc=11 target=80, three wait states
      bus.op_valid  = 1'b1;
      bus.op_code   = 2'b10;
      bus.pc_in     = 8'h11;
      bus.target_in = 8'h80;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.op_valid = 1'b0;
         #1;
         chk("call_wait_strb", strb(), 7'b0010000);
         chk("call_wait", {bus.mem_addr, bus.mem_wdata},
                          {8'hFF, 8'h11});
      end
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1;
      chk("call_rdy_strb", strb(), 7'b0110100);
      chk("call_rdy", {bus.pc_out, bus.mem_wdata, bus.sp_op},
                      {8'h80, 8'h11, 1'b0});
      @(negedge clk);
      bus.sp_in = 8'hFE;
      #1;
      chk("call_done", strb(), 7'b0000010);
      @(negedge clk);
      #1;
      chk("call_idle", bus.op_ready, 1);

      // RET mem=11, with a PUSH request held while busy
      bus.op_valid  = 1'b1;
      bus.op_code   = 2'b11;
      bus.mem_rdata = 8'h11;
      @(negedge clk);
      bus.op_code  = 2'b00;
      bus.op_reg   = 2'b00;
      bus.rf_rdata = 8'hC3;
      #1;
      chk("ret_inc_strb", strb(), 7'b0100000);
      chk("ret_busy", bus.op_ready, 0);
      @(negedge clk);
      bus.sp_in = 8'hFF;
      #1;
      chk("ret_rd_strb", strb(), 7'b0001100);
      chk("ret_rd", {bus.mem_addr, bus.pc_out}, {8'hFF, 8'h11});
      @(negedge clk);
      #1;
      chk("ret_done", {bus.op_ready, strb()}, {1'b0, 7'b0000010});
      @(negedge clk);
      #1;
      chk("ret_idle", {bus.op_ready, strb()}, {1'b1, 7'b0});
      @(negedge clk);
      bus.op_valid = 1'b0;
      #1;
      chk("next_push_strb", strb(), 7'b0110000);
      chk("next_push", {bus.mem_addr, bus.mem_wdata}, {8'hFF, 8'hC3});
      @(negedge clk);
      bus.sp_in = 8'hFE;
      #1;
      chk("next_push_done", strb(), 7'b0000010);
      @(negedge clk);
      #1;

      // POP interrupted by reset in MEM_RD
      bus.op_valid  = 1'b1;
      bus.op_code   = 2'b01;
      bus.op_reg    = 2'b00;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      bus.op_valid = 1'b0;
      #1;
      chk("rmid_inc", strb(), 7'b0100000);
      @(negedge clk);
      bus.sp_in = 8'hFF;
      #1;
      chk("rmid_rd", strb(), 7'b0001000);
      rst = 1'b0;
      #1;
      chk("rmid_strb", strb(), 0);
      chk("rmid_ready", {bus.op_ready, bus.mem_addr}, {1'b1, 8'h00});
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rmid_after", {bus.op_ready, strb()}, {1'b1, 7'b0});

      // POP at SP=FF: guard error, or wrap to 00
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 8'h77;
      bus.op_valid  = 1'b1;
      bus.op_code   = 2'b01;
      bus.op_reg    = 2'b10;
      @(negedge clk);
      bus.op_valid = 1'b0;
      #1;
`ifdef STACK_SEQ_GUARD_EN
      chk("guard_err", strb(), 7'b0000011);
      @(negedge clk);
      #1;
      chk("guard_idle", {bus.op_ready, strb()}, {1'b1, 7'b0});
`else
      chk("wrap_inc_strb", strb(), 7'b0100000);
      chk("wrap_inc_op", bus.sp_op, 1);
      @(negedge clk);
      bus.sp_in = 8'h00;
      #1;
      chk("wrap_rd_strb", strb(), 7'b1001000);
      chk("wrap_rd", {bus.mem_addr, bus.rf_wa, bus.rf_wd},
                     {8'h00, 2'b10, 8'h77});
      @(negedge clk);
      #1;
      chk("wrap_done", strb(), 7'b0000010);
      @(negedge clk);
      #1;
      // PUSH at SP=00 proceeds normally
      bus.op_valid = 1'b1;
      bus.op_code  = 2'b00;
      bus.op_reg   = 2'b01;
      bus.rf_rdata = 8'hA5;
      @(negedge clk);
      bus.op_valid = 1'b0;
      #1;
      chk("wrap_push_strb", strb(), 7'b0110000);
      chk("wrap_push", {bus.mem_addr, bus.mem_wdata}, {8'h00, 8'hA5});
      @(negedge clk);
      bus.sp_in = 8'hFF;
      #1;
      chk("wrap_push_done", strb(), 7'b0000010);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 The block SHALL have these ports, clock and reset first, in the form name, direction, width, meaning:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- op_valid  in  1  stack operation request.
- op_code  in  2  operation: 00 PUSH, 01 POP, 10 CALL, 11 RET.
- op_reg  in  2  source register (PUSH) or destination register (POP).
- pc_in  in  8  return address for CALL.
- target_in  in  8  jump target for CALL.
- sp_in  in  8  current SP, i.e. R3 of the register file.
- rf_rdata  in  8  register file read data for rf_ra.
- mem_rdata  in  8  data memory read data.
- mem_ready  in  1  memory access completes this cycle.
- op_ready  out  1  block can accept an operation.
- rf_ra  out  2  register file read address; combinationally equals op_reg.
- rf_we / rf_wa / rf_wd  out  1/2/8  register file write enable, address and data.
- sp_en / sp_op  out  1/1  SP step enable; sp_op 1 = increment, 0 = decrement.
- mem_addr / mem_wdata  out  8/8  memory address and write data.
- mem_we / mem_re  out  1/1  memory write and read strobes.
- pc_load / pc_out  out  1/8  PC load strobe and value.
- done  out  1  one-cycle completion pulse.
- stack_err  out  1  one-cycle guard-violation pulse.

Function
REQ-002 An operation SHALL be accepted on a rising edge where op_valid=1 and op_ready=1. op_ready SHALL be 1 only in IDLE.
REQ-003 On accept, the block SHALL latch op_code and op_reg. It SHALL also latch the data to store: rf_rdata for PUSH, or pc_in for CALL. For CALL it SHALL also latch target_in.
REQ-004 The FSM states SHALL be IDLE, MEM_WR, SP_INC, MEM_RD and DONE.
REQ-005 Transitions SHALL be:
- PUSH/CALL: IDLE -> MEM_WR -> DONE.
- POP/RET: IDLE -> SP_INC -> MEM_RD -> DONE.
- DONE -> IDLE.
REQ-006 In MEM_WR the block SHALL drive mem_we=1, mem_addr=sp_in and mem_wdata=latched data. It SHALL hold there until mem_ready=1. In that same cycle it SHALL drive sp_en=1 and sp_op=0 (post-decrement).
REQ-007 In MEM_WR for CALL, in the mem_ready cycle, the block SHALL also drive pc_load=1 with pc_out=latched target.
REQ-008 In SP_INC the block SHALL drive sp_en=1 and sp_op=1 for exactly one cycle (pre-increment).
REQ-009 In MEM_RD the block SHALL drive mem_re=1 and mem_addr=sp_in, which is the already-incremented value. It SHALL hold there until mem_ready=1.
REQ-010 In the MEM_RD mem_ready cycle:
- POP SHALL drive rf_we=1, rf_wa=latched op_reg, rf_wd=mem_rdata.
- RET SHALL drive pc_load=1, pc_out=mem_rdata.
REQ-011 In DONE, done SHALL be 1 for one cycle. Every other strobe SHALL be 0.
REQ-012 With mem_ready held at 1, latency from the accept edge to done SHALL be:
- PUSH/CALL: done in the 2nd cycle after accept.
- POP/RET: done in the 3rd cycle after accept.
REQ-013 sp_en and rf_we SHALL never both be 1 in the same cycle.
REQ-014 POP with op_reg=3 SHALL load SP from memory. The SP_INC step still precedes the load.
REQ-015 op_valid outside IDLE SHALL be ignored. The request is not queued.
REQ-016 All strobes (rf_we, sp_en, mem_we, mem_re, pc_load, done, stack_err) SHALL be 0 in IDLE.
REQ-017 Without the guard, SP arithmetic SHALL wrap modulo 256.

Reset
REQ-018 When rst=0 the FSM SHALL go to IDLE immediately, including mid-operation, with all strobes 0 and latched data cleared to 0.
REQ-019 After reset, op_ready SHALL be 1 and every other output SHALL be 0, except rf_ra, which follows op_reg.

Configuration
REQ-020 Macro STACK_SEQ_GUARD_EN, when defined, SHALL enable the guard:
- A PUSH/CALL accepted with sp_in=0, or a POP/RET accepted with sp_in=255, SHALL go IDLE -> DONE.
- No memory, SP, register or PC strobe SHALL be driven for that operation.
- stack_err SHALL be 1 in the same cycle as done.
REQ-021 When STACK_SEQ_GUARD_EN is undefined, stack_err SHALL be tied to 0. All operations SHALL proceed per REQ-005 and wrap per REQ-017.

Verification
REQ-022 PUSH with op_reg=1, R1=0x5A, sp_in=255, mem_ready=1 -> mem_we with addr 0xFF and data 0x5A, sp_en=1 with sp_op=0, done 2 cycles after accept.
REQ-023 POP with op_reg=2, sp_in 254->255, mem_rdata=0x3C -> SP_INC pulse, then mem_re with addr 0xFF, rf_we with wa=2 and wd=0x3C, done 3 cycles after accept.
REQ-024 CALL with pc_in=0x11, target_in=0x80, sp_in=0xFF, mem_ready low for 3 cycles -> mem_we held 4 cycles with data 0x11; pc_load with 0x80 and sp_en only in the ready cycle.
REQ-025 RET with mem_rdata=0x11 -> pc_load with pc_out=0x11. Back-to-back op_valid while busy is ignored; the next op is accepted only when op_ready=1.
REQ-026 rst pulled low during MEM_RD -> all strobes 0 immediately, IDLE, op_ready=1.
REQ-027 Guard: with STACK_SEQ_GUARD_EN, POP at sp_in=255 -> stack_err and done together, no sp_en or mem_re. Without the macro -> normal POP and SP wraps to 0.
